// File: rtl/raccoon_pkg.sv
// raccoon_pkg
// Shared definitions for the raccoon crossing game: the round state
// encodings, the game geometry constants and a small saturating helper.

package raccoon_pkg;

    localparam int c_STATE_W = 3;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_HIT   = 3'd2,
        ST_WIN   = 3'd3,
        ST_OVER  = 3'd4,
        ST_PAUSE = 3'd5
    } state_t;

    // Playfield geometry shared by the position controller and obstacle generators
    localparam int c_GAME_WIDTH    = 640;
    localparam int c_GAME_HEIGHT   = 480;
    localparam int c_PLAYER_SIZE   = 32;
    localparam int c_WIN_Y_DEFAULT = 0;

    // Increment that sticks at the given limit instead of wrapping
    function automatic logic [7:0] sat_inc(input logic [7:0] value, input logic [7:0] limit);
        return (value >= limit) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/raccoon_game_ctrl_if.sv
// raccoon_game_ctrl_if
// Bundles the board/collision inputs and the game status outputs of the
// game sequencer. The master side drives the inputs, the slave side is the
// sequencer itself.

interface raccoon_game_ctrl_if;
    import raccoon_pkg::*;

    logic                 i_Start;
    logic                 i_Collision;
    logic [9:0]           i_Raccoon_Y;
    logic                 o_Tick;
    logic                 o_Move_En;
    logic                 o_Respawn;
    logic [c_STATE_W-1:0] o_State;
    logic [2:0]           o_Lives;
    logic [2:0]           o_Level;
    logic [7:0]           o_Score;

    modport master (
        output i_Start, i_Collision, i_Raccoon_Y,
        input  o_Tick, o_Move_En, o_Respawn, o_State, o_Lives, o_Level, o_Score
    );

    modport slave (
        input  i_Start, i_Collision, i_Raccoon_Y,
        output o_Tick, o_Move_En, o_Respawn, o_State, o_Lives, o_Level, o_Score
    );

endinterface

// File: rtl/raccoon_tick_gen.sv
// raccoon_tick_gen
// Free-running game tick: counts 0..c_TICK_CYCLES-1 and pulses o_Tick in the
// last count. While i_Hold is high the count freezes and no tick is issued.

module raccoon_tick_gen #(
    parameter int c_TICK_CYCLES = 416667
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Hold,
    output logic o_Tick
);

    localparam int                 c_CNT_W = (c_TICK_CYCLES > 1) ? $clog2(c_TICK_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_TICK_CYCLES - 1);

    logic [c_CNT_W-1:0] tick_cnt;

    // Advance the tick counter, wrapping after the last count, frozen while held
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            tick_cnt <= '0;
        end else if (!i_Hold) begin
            tick_cnt <= (tick_cnt == c_LAST) ? '0 : tick_cnt + c_CNT_W'(1);
        end
    end

    assign o_Tick = !i_Hold && (tick_cnt == c_LAST);

endmodule

// File: rtl/raccoon_game_ctrl.sv
// raccoon_game_ctrl
// Round sequencer for the raccoon crossing game: runs IDLE/PLAY/HIT/WIN/OVER,
// gates raccoon movement, requests respawns and tracks lives, level, score.
// Optional feature macro: RACCOON_PAUSE_EN adds a PAUSE state toggled by the
// start button during play, which also freezes the game tick.

module raccoon_game_ctrl
    import raccoon_pkg::*;
#(
    parameter int c_TICK_CYCLES   = 416667,
    parameter int c_LIVES         = 3,
    parameter int c_RESPAWN_TICKS = 60,
    parameter int c_WIN_Y         = c_WIN_Y_DEFAULT,
    parameter int c_MAX_LEVEL     = 7
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    raccoon_game_ctrl_if.slave  bus
);

    localparam int                 c_TMR_W    = $clog2(c_RESPAWN_TICKS + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(c_RESPAWN_TICKS - 1);

    state_t             state_q, state_n;
    logic               start_q;
    logic               start_edge;
    logic [2:0]         lives_q, lives_n;
    logic [2:0]         level_q, level_n;
    logic [7:0]         score_q, score_n;
    logic               respawn_q, respawn_n;
    logic [c_TMR_W-1:0] timer_q, timer_n;
    logic               tick;
    logic               hold;

`ifdef RACCOON_PAUSE_EN
    assign hold = (state_q == ST_PAUSE);
`else
    assign hold = 1'b0;
`endif

    raccoon_tick_gen #(
        .c_TICK_CYCLES (c_TICK_CYCLES)
    ) u_tick_gen (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Hold  (hold),
        .o_Tick  (tick)
    );

    assign start_edge = bus.i_Start & ~start_q;

    // Register the state, game counters, respawn pulse and start history
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            lives_q   <= 3'(c_LIVES);
            level_q   <= 3'd1;
            score_q   <= 8'd0;
            respawn_q <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_n;
            start_q   <= bus.i_Start;
            lives_q   <= lives_n;
            level_q   <= level_n;
            score_q   <= score_n;
            respawn_q <= respawn_n;
            timer_q   <= timer_n;
        end
    end

    // Next-state and counter updates for the round sequence
    always_comb begin
        state_n   = state_q;
        lives_n   = lives_q;
        level_n   = level_q;
        score_n   = score_q;
        respawn_n = 1'b0;
        timer_n   = timer_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge) begin
                    state_n   = ST_PLAY;
                    lives_n   = 3'(c_LIVES);
                    level_n   = 3'd1;
                    score_n   = 8'd0;
                    respawn_n = 1'b1;
                end
            end
            ST_PLAY: begin
                if (bus.i_Collision) begin
                    state_n = ST_HIT;
                    if (lives_q != 3'd0) begin
                        lives_n = lives_q - 3'd1;
                    end
                    timer_n = '0;
                end else if (bus.i_Raccoon_Y <= 10'(c_WIN_Y)) begin
                    state_n = ST_WIN;
                    score_n = sat_inc(score_q, 8'd255);
                    level_n = 3'(sat_inc({5'd0, level_q}, 8'(c_MAX_LEVEL)));
                    timer_n = '0;
                end
`ifdef RACCOON_PAUSE_EN
                else if (start_edge) begin
                    state_n = ST_PAUSE;
                end
`endif
            end
            ST_HIT: begin
                if (tick) begin
                    if (timer_q == c_TMR_LAST) begin
                        if (lives_q == 3'd0) begin
                            state_n = ST_OVER;
                        end else begin
                            state_n   = ST_PLAY;
                            respawn_n = 1'b1;
                        end
                    end else begin
                        timer_n = timer_q + c_TMR_W'(1);
                    end
                end
            end
            ST_WIN: begin
                if (tick) begin
                    if (timer_q == c_TMR_LAST) begin
                        state_n   = ST_PLAY;
                        respawn_n = 1'b1;
                    end else begin
                        timer_n = timer_q + c_TMR_W'(1);
                    end
                end
            end
`ifdef RACCOON_PAUSE_EN
            ST_PAUSE: begin
                if (start_edge) begin
                    state_n = ST_PLAY;
                end
            end
`endif
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign bus.o_Tick    = tick;
    assign bus.o_Move_En = (state_q == ST_PLAY);
    assign bus.o_Respawn = respawn_q;
    assign bus.o_State   = state_q;
    assign bus.o_Lives   = lives_q;
    assign bus.o_Level   = level_q;
    assign bus.o_Score   = score_q;

endmodule

// File: tb/tb_raccoon_game_ctrl.sv
// tb_raccoon_game_ctrl
// Directed bench for raccoon_game_ctrl with a 4-cycle tick, 2 lives,
// 2-tick respawn delay and level limit 3. Expected values are hand-derived;
// the tick expectation comes from a cycle counter kept by the bench.
// Build with RACCOON_PAUSE_EN to also exercise the pause option.

module tb_raccoon_game_ctrl;

    localparam int c_TICKS = 4;

    logic clk;
    logic rst_n;

    int numChecks   = 0;
    int numFails    = 0;
    int cycleCount  = 0;
    bit tbPaused    = 0;
    bit tbPausedNxt = 0;

    raccoon_game_ctrl_if bus ();

    raccoon_game_ctrl #(
        .c_TICK_CYCLES   (4),
        .c_LIVES         (2),
        .c_RESPAWN_TICKS (2),
        .c_WIN_Y         (0),
        .c_MAX_LEVEL     (3)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its expected value and log mismatches
    task automatic checkOutput(input string tag, input int actual, input int expected);
        numChecks++;
        if (actual != expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive the three data inputs of the sequencer
    task automatic applyStimulus(input logic start, input logic collision, input logic [9:0] y);
        bus.i_Start     = start;
        bus.i_Collision = collision;
        bus.i_Raccoon_Y = y;
    endtask

    // Advance one clock, update the tick model and check o_Tick against it
    task automatic stepCycle();
        bit wasPaused;
        wasPaused = tbPaused;
        @(posedge clk);
        #1;
        if (!wasPaused) cycleCount++;
        tbPaused = tbPausedNxt;
        checkOutput("tick", int'(bus.o_Tick),
                    int'(!tbPaused && ((cycleCount % c_TICKS) == c_TICKS - 1)));
    endtask

    // Step until the state leaves fromState, counting ticks seen while in it
    task automatic waitExit(input int fromState, output int ticksSeen);
        int budget;
        ticksSeen = 0;
        budget    = 0;
        while (int'(bus.o_State) == fromState && budget < 50) begin
            if (bus.o_Tick) ticksSeen++;
            stepCycle();
            budget++;
        end
        checkOutput("exit_timeout", int'(int'(bus.o_State) == fromState), 0);
    endtask

    initial begin
        int respawnCount;
        int ticks;

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 10'd100);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_state", int'(bus.o_State), 0);
        checkOutput("rst_lives", int'(bus.o_Lives), 2);
        checkOutput("rst_level", int'(bus.o_Level), 1);
        checkOutput("rst_score", int'(bus.o_Score), 0);
        checkOutput("rst_move", int'(bus.o_Move_En), 0);
        checkOutput("rst_respawn", int'(bus.o_Respawn), 0);
        rst_n = 1'b1;
        cycleCount = 0;

        // Test 1: free-running tick in IDLE
        checkOutput("tick0", int'(bus.o_Tick), 0);
        for (int i = 0; i < 12; i++) stepCycle();
        checkOutput("t1_state", int'(bus.o_State), 0);
        checkOutput("t1_lives", int'(bus.o_Lives), 2);
        checkOutput("t1_level", int'(bus.o_Level), 1);
        checkOutput("t1_score", int'(bus.o_Score), 0);

        // Test 2: held start gives one transition and one respawn
        applyStimulus(1'b1, 1'b0, 10'd100);
        respawnCount = 0;
        stepCycle();
        checkOutput("t2_first_state", int'(bus.o_State), 1);
        checkOutput("t2_first_respawn", int'(bus.o_Respawn), 1);
        if (bus.o_Respawn) respawnCount++;
        for (int i = 0; i < 9; i++) begin
            stepCycle();
            if (bus.o_Respawn) respawnCount++;
        end
        checkOutput("t2_respawns", respawnCount, 1);
        checkOutput("t2_state", int'(bus.o_State), 1);
        checkOutput("t2_move", int'(bus.o_Move_En), 1);
        applyStimulus(1'b0, 1'b0, 10'd100);
        stepCycle();

        // Test 3: collision beats a simultaneous win
        applyStimulus(1'b0, 1'b1, 10'd0);
        stepCycle();
        checkOutput("t3_state", int'(bus.o_State), 2);
        checkOutput("t3_lives", int'(bus.o_Lives), 1);
        checkOutput("t3_score", int'(bus.o_Score), 0);
        checkOutput("t3_move", int'(bus.o_Move_En), 0);
        applyStimulus(1'b0, 1'b0, 10'd100);
        waitExit(2, ticks);
        checkOutput("t3_ticks", ticks, 2);
        checkOutput("t3_back_state", int'(bus.o_State), 1);
        checkOutput("t3_respawn", int'(bus.o_Respawn), 1);
        stepCycle();
        checkOutput("t3_respawn_end", int'(bus.o_Respawn), 0);

        // Test 4: last life lost leads to OVER, then restart
        applyStimulus(1'b0, 1'b1, 10'd100);
        stepCycle();
        checkOutput("t4_state", int'(bus.o_State), 2);
        checkOutput("t4_lives", int'(bus.o_Lives), 0);
        applyStimulus(1'b0, 1'b0, 10'd100);
        waitExit(2, ticks);
        checkOutput("t4_ticks", ticks, 2);
        checkOutput("t4_over", int'(bus.o_State), 4);
        checkOutput("t4_no_respawn", int'(bus.o_Respawn), 0);
        checkOutput("t4_move", int'(bus.o_Move_En), 0);
        stepCycle();
        stepCycle();
        checkOutput("t4_over_hold", int'(bus.o_State), 4);
        checkOutput("t4_over_lives", int'(bus.o_Lives), 0);
        applyStimulus(1'b1, 1'b0, 10'd100);
        stepCycle();
        checkOutput("t4_restart_state", int'(bus.o_State), 1);
        checkOutput("t4_restart_lives", int'(bus.o_Lives), 2);
        checkOutput("t4_restart_score", int'(bus.o_Score), 0);
        checkOutput("t4_restart_respawn", int'(bus.o_Respawn), 1);
        applyStimulus(1'b0, 1'b0, 10'd100);
        stepCycle();

        // Test 5: four wins, level saturates at 3
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 1'b0, 10'd0);
            stepCycle();
            checkOutput("t5_win_state", int'(bus.o_State), 3);
            checkOutput("t5_score", int'(bus.o_Score), k);
            checkOutput("t5_level", int'(bus.o_Level), (k + 1 > 3) ? 3 : k + 1);
            applyStimulus(1'b1, 1'b1, 10'd100);
            stepCycle();
            checkOutput("t5_win_ignores", int'(bus.o_State), 3);
            applyStimulus(1'b0, 1'b0, 10'd100);
            waitExit(3, ticks);
            checkOutput("t5_back_play", int'(bus.o_State), 1);
            checkOutput("t5_respawn", int'(bus.o_Respawn), 1);
            checkOutput("t5_lives", int'(bus.o_Lives), 2);
        end
        checkOutput("t5_final_score", int'(bus.o_Score), 4);
        checkOutput("t5_final_level", int'(bus.o_Level), 3);

        // Test 6: asynchronous reset in the middle of WIN
        applyStimulus(1'b0, 1'b0, 10'd0);
        stepCycle();
        checkOutput("t6_in_win", int'(bus.o_State), 3);
        applyStimulus(1'b0, 1'b0, 10'd100);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_state", int'(bus.o_State), 0);
        checkOutput("t6_lives", int'(bus.o_Lives), 2);
        checkOutput("t6_level", int'(bus.o_Level), 1);
        checkOutput("t6_score", int'(bus.o_Score), 0);
        checkOutput("t6_move", int'(bus.o_Move_En), 0);
        checkOutput("t6_tick", int'(bus.o_Tick), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycleCount = 0;
        for (int i = 0; i < 5; i++) stepCycle();
        checkOutput("t6_idle", int'(bus.o_State), 0);

`ifdef RACCOON_PAUSE_EN
        // Pause option: start edge in PLAY freezes the tick until the next edge
        applyStimulus(1'b1, 1'b0, 10'd100);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 10'd100);
        stepCycle();
        checkOutput("p_play", int'(bus.o_State), 1);
        applyStimulus(1'b1, 1'b0, 10'd100);
        tbPausedNxt = 1;
        stepCycle();
        checkOutput("p_state", int'(bus.o_State), 5);
        checkOutput("p_move", int'(bus.o_Move_En), 0);
        applyStimulus(1'b0, 1'b1, 10'd0);
        for (int i = 0; i < 8; i++) begin
            stepCycle();
            checkOutput("p_hold_state", int'(bus.o_State), 5);
            checkOutput("p_hold_tick", int'(bus.o_Tick), 0);
        end
        applyStimulus(1'b1, 1'b0, 10'd100);
        tbPausedNxt = 0;
        stepCycle();
        checkOutput("p_resume", int'(bus.o_State), 1);
        checkOutput("p_no_respawn", int'(bus.o_Respawn), 0);
        applyStimulus(1'b0, 1'b0, 10'd100);
        for (int i = 0; i < 6; i++) stepCycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

    // Watchdog so the run always ends even if the design stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/raccoon_game_ctrl.md
Name: raccoon_game_ctrl

Overview:
Game-level sequencer for the raccoon crossing game. It runs the round state machine (idle, play, hit, win, game over) and generates the game tick. It gates raccoon movement, requests respawns to the start position, and tracks lives, level and score. It sits between the board buttons/collision detector and the raccoon position controller and obstacle generators.

Parameters:
c_TICK_CYCLES, 416667, clock cycles per game tick (25 MHz / 60 Hz)
c_LIVES, 3, lives at game start (1..7)
c_RESPAWN_TICKS, 60, ticks spent in HIT or WIN before respawn (>=1)
c_WIN_Y, 0, raccoon Y at or below which the crossing counts as a win
c_MAX_LEVEL, 7, level saturation value (1..7)

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_Start  in  1  start button, level, already debounced
i_Collision  in  1  raccoon/obstacle overlap, level, synchronous to i_Clk
i_Raccoon_Y  in  10  current raccoon Y position
o_Tick  out  1  one-cycle game tick pulse
o_Move_En  out  1  raccoon movement permitted
o_Respawn  out  1  one-cycle pulse: reload raccoon to start position
o_State  out  3  IDLE=0, PLAY=1, HIT=2, WIN=3, OVER=4 (PAUSE=5 with option)
o_Lives  out  3  remaining lives
o_Level  out  3  current level, 1-based
o_Score  out  8  completed crossings

Behaviour:
- Reset (async assert, sync release): state IDLE, tick counter 0, all pulses 0, o_Move_En 0, o_Lives=c_LIVES, o_Level=1, o_Score=0, start-edge register 0. Reset mid-round discards everything.
- Tick: counter runs 0..c_TICK_CYCLES-1 from reset. o_Tick=1 exactly in the cycle the counter equals c_TICK_CYCLES-1, then the counter wraps to 0. It is free-running in every state, except PAUSE under the option.
- Start edge: i_Start is registered; edge = i_Start & ~prev. Holding the button gives one edge only.
- Moore outputs: o_Move_En=1 only in PLAY. o_State mirrors the state register.
- IDLE / OVER: on start edge, go to PLAY next cycle. In the same cycle load o_Lives=c_LIVES, o_Level=1, o_Score=0 and pulse o_Respawn. In OVER, the counters hold their final values until then.
- PLAY, evaluated each cycle with this priority:
  - i_Collision=1: go to HIT, o_Lives-1, clear the respawn timer.
  - else i_Raccoon_Y <= c_WIN_Y: go to WIN, o_Score+1 saturating at 255, o_Level+1 saturating at c_MAX_LEVEL, clear the timer.
  - A start edge in PLAY is ignored when the option is off.
- HIT: i_Collision is ignored. The timer increments on each o_Tick. When the timer reaches c_RESPAWN_TICKS-1 and o_Tick=1:
  - if o_Lives==0, go to OVER with no respawn;
  - else go to PLAY and pulse o_Respawn.
- WIN: same timer rule, then go to PLAY with an o_Respawn pulse. Collision is ignored.
- Every state update is registered: a condition sampled in cycle N is visible on outputs in cycle N+1. o_Respawn is high for exactly one cycle, coincident with the first cycle of PLAY.
- o_Lives never underflows: it reaches 0 only through a HIT, and HIT with o_Lives==0 exits to OVER.
- Illegal state encodings recover to IDLE.

Optional Feature:
RACCOON_PAUSE_EN.
- Defined: a start edge in PLAY enters PAUSE (encoding 5); a start edge in PAUSE returns to PLAY with no respawn. In PAUSE, o_Move_En=0, the tick counter holds its value, o_Tick=0 and collision is ignored.
- Undefined: the PAUSE state and its logic are absent, and a start edge in PLAY is ignored.

Decomposition:
- Shared package raccoon_pkg holds:
  - the state encodings (IDLE..PAUSE) and 3-bit state width;
  - the shared game geometry constants (game width/height, player size, c_WIN_Y default).
- One sub-module, raccoon_tick_gen: the tick counter with a hold input (tied low unless the option is defined), output o_Tick.

Test Plan (c_TICK_CYCLES=4, c_LIVES=2, c_RESPAWN_TICKS=2, c_MAX_LEVEL=3):
1. Reset, then run 12 cycles -> o_Tick high at cycles 3, 7, 11; state IDLE, o_Lives=2, o_Level=1, o_Score=0.
2. i_Start held high for 10 cycles in IDLE -> a single o_Respawn pulse, state PLAY, o_Move_En=1; no second transition.
3. In PLAY, i_Collision=1 and i_Raccoon_Y=0 in the same cycle -> HIT (collision wins), o_Lives=1, o_Score unchanged; after 2 ticks, o_Respawn pulses and state is PLAY.
4. With o_Lives=1, collide again -> o_Lives=0, HIT; after 2 ticks, state OVER, no o_Respawn, o_Move_En=0. Then a start edge -> PLAY, o_Lives=2, o_Score=0.
5. Four wins via i_Raccoon_Y=0 -> o_Score=4, o_Level saturates at 3.
6. Assert i_Rst_n=0 mid-WIN -> outputs immediately at reset values, state IDLE. With RACCOON_PAUSE_EN: a start edge in PLAY freezes the tick counter and holds o_Tick=0 until the next edge.
